// File: rtl/dcache_trans_pkg.sv
// ----------------------------------------------------------------------------
// dcache_trans_pkg
// Shared types and constants for the data-side translation requester.
//   - ADDR_W / DATA_W / STRB_W : datapath widths
//   - TIMEOUT_CYCLES_DEF       : default uncached-response timeout
//   - UC_ERR_DATA              : read data returned on an uncached timeout
//   - trans_state_e            : requester FSM states
//   - trans_req_t              : captured pipeline request
//   - uc_strb()                : byte enables presented on the uncached bus
// ----------------------------------------------------------------------------
package dcache_trans_pkg;

    localparam int ADDR_W             = 32;
    localparam int DATA_W             = 32;
    localparam int STRB_W             = DATA_W / 8;
    localparam int TIMEOUT_CYCLES_DEF = 256;

    localparam logic [DATA_W-1:0] UC_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_XLATE   = 3'd1,
        ST_CACHED  = 3'd2,
        ST_UC_REQ  = 3'd3,
        ST_UC_WAIT = 3'd4
    } trans_state_e;

    typedef struct packed {
        logic              we;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] vaddr;
        logic [DATA_W-1:0] wdata;
        logic              cacop_di;
    } trans_req_t;

    // Loads must not present any byte enables on the uncached bus.
    function automatic logic [STRB_W-1:0] uc_strb(input logic we,
                                                  input logic [STRB_W-1:0] wstrb);
        logic [STRB_W-1:0] strb_s;
        if (we) begin
            strb_s = wstrb;
        end else begin
            strb_s = {STRB_W{1'b0}};
        end
        return strb_s;
    endfunction

endpackage

// File: rtl/uc_timeout_cnt.sv
// ----------------------------------------------------------------------------
// uc_timeout_cnt
// Cycle counter for the uncached-response wait. Built into dcache_trans_req
// only when DCACHE_UC_TIMEOUT_EN is defined.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force the count back to zero
//   enable   : count one cycle
//   expire   : high in the CYCLES-th enabled cycle after a clear
// ----------------------------------------------------------------------------
module uc_timeout_cnt
    import dcache_trans_pkg::*;
#(
    parameter int CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CNT_W-1:0] cnt_r;

    assign expire = enable && (cnt_r == CNT_W'(CYCLES - 1));

    // Elapsed-cycle counter; saturates at expiry so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable && !expire) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/dcache_trans_req.sv
// ----------------------------------------------------------------------------
// dcache_trans_req
// Data-side initiator of the address-translation interface. Takes one
// load/store from the MEM stage, presents its vaddr to the translator, captures
// the returned paddr/uncache flag one cycle later, then either hands the access
// to the dcache lookup (cached) or runs one request/response on the uncached
// bus. One transaction outstanding at a time.
//
// Optional feature: define DCACHE_UC_TIMEOUT_EN to abort an uncached access
// after TIMEOUT_CYCLES without response (rsp_err=1, rsp_rdata=UC_ERR_DATA).
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_*                          pipeline request (valid/ready)
//   data_vaddr, cacop_op_mode_di   to translator
//   ret_data_paddr, ret_uncache    from translator, one cycle after vaddr
//   hit_*                          cached hand-off to dcache lookup
//   ub_req_*, ub_addr/we/wstrb/wdata, ub_rsp_valid, ub_rdata
//                                  single-beat uncached bus
//   rsp_valid, rsp_rdata, rsp_err  uncached completion to pipeline
// Widths come from dcache_trans_pkg (ADDR_W, DATA_W, STRB_W).
// ----------------------------------------------------------------------------
module dcache_trans_req
    import dcache_trans_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [STRB_W-1:0] req_wstrb,
    input  logic [ADDR_W-1:0] req_vaddr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_cacop_di,
    output logic [ADDR_W-1:0] data_vaddr,
    output logic              cacop_op_mode_di,
    input  logic [ADDR_W-1:0] ret_data_paddr,
    input  logic              ret_uncache,
    output logic              hit_valid,
    input  logic              hit_ready,
    output logic [ADDR_W-1:0] hit_paddr,
    output logic              hit_we,
    output logic [STRB_W-1:0] hit_wstrb,
    output logic [DATA_W-1:0] hit_wdata,
    output logic              ub_req_valid,
    input  logic              ub_req_ready,
    output logic [ADDR_W-1:0] ub_addr,
    output logic              ub_we,
    output logic [STRB_W-1:0] ub_wstrb,
    output logic [DATA_W-1:0] ub_wdata,
    input  logic              ub_rsp_valid,
    input  logic [DATA_W-1:0] ub_rdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    trans_state_e      state_r;
    trans_state_e      state_s;
    trans_req_t        req_r;
    logic [ADDR_W-1:0] paddr_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              rsp_err_r;
    logic              uc_expire_s;
    logic              rsp_fire_s;
    logic              is_idle_s;

`ifdef DCACHE_UC_TIMEOUT_EN
    // Held clear for the whole request phase so it starts from 0 in UC_WAIT.
    uc_timeout_cnt #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_uc_timeout_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_r == ST_UC_REQ),
        .enable (state_r == ST_UC_WAIT),
        .expire (uc_expire_s)
    );
`else
    logic unused_cfg_s;
    assign unused_cfg_s = (TIMEOUT_CYCLES > 0);
    assign uc_expire_s  = 1'b0;
`endif

    assign is_idle_s  = (state_r == ST_IDLE);
    // A real response wins over a timeout that expires in the same cycle.
    assign rsp_fire_s = (state_r == ST_UC_WAIT) && (ub_rsp_valid || uc_expire_s);

    // In IDLE the translator sees the live request so translation starts in
    // the accept cycle; afterwards it sees the captured copy.
    assign req_ready        = is_idle_s;
    assign data_vaddr       = is_idle_s ? req_vaddr    : req_r.vaddr;
    assign cacop_op_mode_di = is_idle_s ? req_cacop_di : req_r.cacop_di;

    assign hit_valid = (state_r == ST_CACHED);
    assign hit_paddr = paddr_r;
    assign hit_we    = req_r.we;
    assign hit_wstrb = req_r.wstrb;
    assign hit_wdata = req_r.wdata;

    assign ub_req_valid = (state_r == ST_UC_REQ);
    assign ub_addr      = paddr_r;
    assign ub_we        = req_r.we;
    assign ub_wstrb     = uc_strb(req_r.we, req_r.wstrb);
    assign ub_wdata     = req_r.wdata;

    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_s = ST_XLATE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_XLATE: begin
                if (ret_uncache) begin
                    state_s = ST_UC_REQ;
                end else begin
                    state_s = ST_CACHED;
                end
            end
            ST_CACHED: begin
                if (hit_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_CACHED;
                end
            end
            ST_UC_REQ: begin
                if (ub_req_ready) begin
                    state_s = ST_UC_WAIT;
                end else begin
                    state_s = ST_UC_REQ;
                end
            end
            ST_UC_WAIT: begin
                if (rsp_fire_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_UC_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Request capture on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_r <= '0;
        end else if (is_idle_s && req_valid) begin
            req_r.we       <= req_we;
            req_r.wstrb    <= req_wstrb;
            req_r.vaddr    <= req_vaddr;
            req_r.wdata    <= req_wdata;
            req_r.cacop_di <= req_cacop_di;
        end else begin
            req_r <= req_r;
        end
    end

    // Translated address capture in the single XLATE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            paddr_r <= {ADDR_W{1'b0}};
        end else if (state_r == ST_XLATE) begin
            paddr_r <= ret_data_paddr;
        end else begin
            paddr_r <= paddr_r;
        end
    end

    // Uncached completion: one-cycle pulse, data/err held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
        end else if (rsp_fire_s) begin
            rsp_valid_r <= 1'b1;
            if (ub_rsp_valid) begin
                rsp_err_r <= 1'b0;
                if (req_r.we) begin
                    rsp_rdata_r <= {DATA_W{1'b0}};
                end else begin
                    rsp_rdata_r <= ub_rdata;
                end
            end else begin
                rsp_err_r   <= 1'b1;
                rsp_rdata_r <= UC_ERR_DATA;
            end
        end else begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= rsp_rdata_r;
            rsp_err_r   <= rsp_err_r;
        end
    end

endmodule
